mem_arbiter_2b: RTL

Two-port block-transfer arbiter and sequencer sharing one `memory` instance between two `cache_2b`-style requesters, e.g. an instruction cache and a data cache. Each requester issues a 128-bit block refill (read) or writeback (write). The arbiter grants one requester at a time, drives the memory bus for a fixed latency, captures the read block and returns a one-cycle done pulse. It sits between the caches and the memory in the top-level data bus, replacing the direct cache-to-memory wiring.

---
 rtl/mem_arbiter_2b.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_2b.sv
// Two-port block-transfer arbiter/sequencer in front of one shared memory.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins) instead of round-robin.
module mem_arbiter_2b #(
    parameter int MEM_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         isMemRead0,
    input  logic         isMemRead1,
    input  logic [9:0]   address0,
    input  logic [9:0]   address1,
    input  logic [127:0] writeData0,
    input  logic [127:0] writeData1,
    output logic         grant0,
    output logic         grant1,
    output logic         done0,
    output logic         done1,
    output logic [127:0] readData0,
    output logic [127:0] readData1,
    output logic         isMemRead,
    output logic         isLock,
    output logic [31:0]  memAddress,
    output logic [127:0] memWriteData,
    input  logic [127:0] memReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t       state, state_nx;
    logic [3:0]   cnt, cnt_nx;
    logic         sel, sel_nx;
    logic         win;
    logic         grant0_nx, grant1_nx, done0_nx, done1_nx, lock_nx, rd_nx;
    logic [31:0]  addr_nx;
    logic [127:0] wdata_nx, rdata0_nx, rdata1_nx;
    logic [9:0]   win_addr;

    // Byte offset within the block is never forwarded to memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address0[3:0], address1[3:0]};

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win = req0 ? 1'b0 : 1'b1;
`else
    logic last_grant;
    // On a tie the port that did not go last wins; a lone requester always wins.
    assign win = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (state == IDLE && (req0 || req1))
            last_grant <= win;
    end
`endif

    assign win_addr = win ? address1 : address0;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sel_nx    = sel;
        grant0_nx = 1'b0;
        grant1_nx = 1'b0;
        done0_nx  = 1'b0;
        done1_nx  = 1'b0;
        lock_nx   = 1'b0;
        rd_nx     = isMemRead;
        addr_nx   = memAddress;
        wdata_nx  = memWriteData;
        rdata0_nx = readData0;
        rdata1_nx = readData1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx  = ACCESS;
                    sel_nx    = win;
                    cnt_nx    = 4'(MEM_LATENCY - 1);
                    rd_nx     = win ? isMemRead1 : isMemRead0;
                    addr_nx   = {22'b0, win_addr[9:4], 4'b0};
                    wdata_nx  = win ? writeData1 : writeData0;
                    lock_nx   = 1'b1;
                    grant0_nx = ~win;
                    grant1_nx = win;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    // Memory data is valid only in the final access cycle.
                    state_nx = DONE;
                    done0_nx = ~sel;
                    done1_nx = sel;
                    if (isMemRead) begin
                        if (sel) rdata1_nx = memReadData;
                        else     rdata0_nx = memReadData;
                    end
                end else begin
                    cnt_nx    = cnt - 4'd1;
                    lock_nx   = 1'b1;
                    grant0_nx = ~sel;
                    grant1_nx = sel;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            sel          <= 1'b0;
            grant0       <= 1'b0;
            grant1       <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            isLock       <= 1'b0;
            isMemRead    <= 1'b0;
            memAddress   <= 32'd0;
            memWriteData <= 128'd0;
            readData0    <= 128'd0;
            readData1    <= 128'd0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            sel          <= sel_nx;
            grant0       <= grant0_nx;
            grant1       <= grant1_nx;
            done0        <= done0_nx;
            done1        <= done1_nx;
            isLock       <= lock_nx;
            isMemRead    <= rd_nx;
            memAddress   <= addr_nx;
            memWriteData <= wdata_nx;
            readData0    <= rdata0_nx;
            readData1    <= rdata1_nx;
        end
    end
endmodule
